// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//
// Executes the push/pop register-list masks produced by pre-decode (PUSH R,
// POP R, CALL, INT, RETI, PREPARE). Each set mask bit becomes one word-sized
// stack bus transfer. Pushes walk the mask from the lowest slot upwards and
// pops walk it from the highest slot downwards. The working SP is updated per
// transfer and popped words are returned to the register file.
//
// Optional feature macro: STACK_SEQ_BACK2BACK_EN
//   defined   : the next item's request follows mem_ack_i with no idle cycle.
//   undefined : mem_req_o drops for exactly one cycle after every mem_ack_i
//               that leaves further items pending.
//
// Ports
//   clk_i        core clock
//   reset_i      asynchronous, active-high reset (aborts any bus request)
//   start_i      1-cycle request, sampled only while busy_o = 0
//   push_mask_i  slots to push (captured on start)
//   pop_mask_i   slots to pop (captured on start)
//   sp_i         current SP (captured on start)
//   reg_idx_o    slot whose value is needed for the current push
//   reg_rdata_i  combinational register-file value of slot reg_idx_o
//   mem_req_o    stack transfer request
//   mem_wr_o     1 = write (push), 0 = read (pop)
//   mem_addr_o   SS-relative stack offset
//   mem_wdata_o  push data
//   mem_ack_i    transfer complete; mem_rdata_i valid this cycle on reads
//   mem_rdata_i  pop data
//   wb_valid_o   1-cycle pulse: write wb_data_o into slot wb_idx_o
//   wb_idx_o     writeback slot
//   wb_data_o    popped value
//   sp_o         working SP
//   sp_we_o      1-cycle pulse when sp_o changed
//   busy_o       sequence in progress
//   done_o       1-cycle pulse when the sequence completes
// -----------------------------------------------------------------------------
module stack_sequencer #(
   parameter int MASK_W = 16,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int STEP   = 2,
   parameter int IDX_W  = $clog2(MASK_W)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [MASK_W-1:0] push_mask_i,
   input  logic [MASK_W-1:0] pop_mask_i,
   input  logic [ADDR_W-1:0] sp_i,
   output logic [IDX_W-1:0]  reg_idx_o,
   input  logic [DATA_W-1:0] reg_rdata_i,
   output logic              mem_req_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              wb_valid_o,
   output logic [IDX_W-1:0]  wb_idx_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [ADDR_W-1:0] sp_o,
   output logic              sp_we_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_GAP} state_t;

   localparam logic [IDX_W-1:0]  SLOT_SP      = IDX_W'(4);
   localparam logic [IDX_W-1:0]  SLOT_DISCARD = IDX_W'(5);
   localparam logic [ADDR_W-1:0] STEP_A       = ADDR_W'(STEP);

   function automatic logic [IDX_W-1:0] lowest_set(input logic [MASK_W-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] highest_set(input logic [MASK_W-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MASK_W; i++) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   state_t            state_q;
   logic [MASK_W-1:0] push_q;
   logic [MASK_W-1:0] pop_q;
   logic [ADDR_W-1:0] sp_q;
   logic [ADDR_W-1:0] sp_cap_q;
   logic [IDX_W-1:0]  slot_q;
   logic              mem_req_q;
   logic              mem_wr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              wb_valid_q;
   logic [IDX_W-1:0]  wb_idx_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              sp_we_q;
   logic              busy_q;
   logic              done_q;

   logic [MASK_W-1:0] slot_bit_d;
   logic [MASK_W-1:0] push_clr_d;
   logic [MASK_W-1:0] pop_clr_d;
   logic [MASK_W-1:0] src_push_d;
   logic [MASK_W-1:0] src_pop_d;
   logic [ADDR_W-1:0] src_sp_d;
   logic [ADDR_W-1:0] launch_sp_d;
   logic [IDX_W-1:0]  launch_slot_d;
   logic              sel_push_d;
   logic              any_item_d;
   logic              ack_d;
   logic              accept_d;
   logic              item_end_d;
   logic              go_launch_d;
   logic              go_gap_d;
   logic              go_finish_d;

   // Work out which item (if any) comes next, using the masks and SP as they
   // will stand once the current event (start, ack) has been applied. This one
   // selection serves the start, back-to-back and post-bubble paths alike.
   always_comb begin
      slot_bit_d = MASK_W'(1) << slot_q;
      push_clr_d = push_q & ~slot_bit_d;
      pop_clr_d  = pop_q & ~slot_bit_d;
      ack_d      = mem_req_q & mem_ack_i;   // ack without a request is ignored
      accept_d   = (state_q == S_IDLE) && start_i;
      item_end_d = ack_d && ((state_q == S_PUSH) || (state_q == S_POP));

      src_push_d = push_q;
      src_pop_d  = pop_q;
      src_sp_d   = sp_q;
      case (state_q)
         S_IDLE: begin
            src_push_d = push_mask_i;
            src_pop_d  = pop_mask_i;
            src_sp_d   = sp_i;
         end
         S_PUSH: src_push_d = push_clr_d;
         S_POP: begin
            src_pop_d = pop_clr_d;
            src_sp_d  = sp_q + STEP_A;
         end
         default: ;
      endcase

      sel_push_d    = |src_push_d;
      any_item_d    = sel_push_d | (|src_pop_d);
      launch_slot_d = sel_push_d ? lowest_set(src_push_d) : highest_set(src_pop_d);
      // Pushes pre-decrement SP; pops read at the current SP.
      launch_sp_d   = sel_push_d ? (src_sp_d - STEP_A) : src_sp_d;

      go_finish_d = (accept_d || item_end_d) && !any_item_d;
`ifdef STACK_SEQ_BACK2BACK_EN
      go_gap_d    = 1'b0;
      go_launch_d = (accept_d || item_end_d || (state_q == S_GAP)) && any_item_d;
`else
      go_gap_d    = item_end_d && any_item_d;
      go_launch_d = (accept_d || (state_q == S_GAP)) && any_item_d;
`endif
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         push_q     <= '0;
         pop_q      <= '0;
         sp_q       <= '0;
         sp_cap_q   <= '0;
         slot_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         wb_valid_q <= 1'b0;
         wb_idx_q   <= '0;
         wb_data_q  <= '0;
         sp_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         sp_we_q    <= 1'b0;
         wb_valid_q <= 1'b0;
         done_q     <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  push_q   <= push_mask_i;
                  pop_q    <= pop_mask_i;
                  sp_cap_q <= sp_i;
                  sp_q     <= sp_i;
               end
            end
            S_PUSH: begin
               if (ack_d) push_q <= push_clr_d;
            end
            S_POP: begin
               if (ack_d) begin
                  pop_q     <= pop_clr_d;
                  sp_q      <= sp_q + STEP_A;
                  sp_we_q   <= 1'b1;
                  // SP and the discard slot are read off the stack but never written back.
                  wb_valid_q <= (slot_q != SLOT_SP) && (slot_q != SLOT_DISCARD);
                  wb_idx_q   <= slot_q;
                  wb_data_q  <= mem_rdata_i;
               end
            end
            default: ;
         endcase

         if (go_launch_d) begin
            state_q    <= sel_push_d ? S_PUSH : S_POP;
            busy_q     <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_wr_q   <= sel_push_d;
            mem_addr_q <= launch_sp_d;
            slot_q     <= launch_slot_d;
            sp_q       <= launch_sp_d;
            if (sel_push_d) sp_we_q <= 1'b1;
         end else if (go_gap_d) begin
            state_q   <= S_GAP;
            mem_req_q <= 1'b0;
         end else if (go_finish_d) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            done_q    <= 1'b1;
         end
      end
   end

   assign reg_idx_o   = slot_q;
   assign mem_req_o   = mem_req_q;
   assign mem_wr_o    = mem_wr_q;
   assign mem_addr_o  = mem_addr_q;
   // The SP slot pushes the SP value from before the sequence, not the live register.
   assign mem_wdata_o = (mem_req_q && mem_wr_q) ?
                        ((slot_q == SLOT_SP) ? DATA_W'(sp_cap_q) : reg_rdata_i) : '0;
   assign wb_valid_o  = wb_valid_q;
   assign wb_idx_o    = wb_idx_q;
   assign wb_data_o   = wb_data_q;
   assign sp_o        = sp_q;
   assign sp_we_o     = sp_we_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_stack_sequencer.sv
`timescale 1ns/1ps
module tb_stack_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] push_mask = '0;
   logic [15:0] pop_mask = '0;
   logic [15:0] sp_in = '0;
   logic [3:0]  reg_idx;
   logic [15:0] reg_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        wb_valid;
   logic [3:0]  wb_idx;
   logic [15:0] wb_data;
   logic [15:0] sp_out;
   logic        sp_we;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   stack_sequencer dut (
      .clk_i(clk), .reset_i(reset), .start_i(start),
      .push_mask_i(push_mask), .pop_mask_i(pop_mask), .sp_i(sp_in),
      .reg_idx_o(reg_idx), .reg_rdata_i(reg_rdata),
      .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
      .wb_valid_o(wb_valid), .wb_idx_o(wb_idx), .wb_data_o(wb_data),
      .sp_o(sp_out), .sp_we_o(sp_we), .busy_o(busy), .done_o(done)
   );

   typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } bus_t;
   typedef struct { logic [3:0] idx; logic [15:0] data; } wb_t;
   typedef struct { logic [15:0] sp; int n_spwe; int n_gap; bit has_items; } done_t;

   bus_t  bus_q[$];
   wb_t   wb_exp_q[$];
   done_t done_exp_q[$];

   int checks = 0;
   int errors = 0;

   logic [15:0] regfile [16];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] biu_mem [logic [15:0]];

   int ack_mode = 0;     // 0 = ack at once, 1 = random stalls, 2 = hold off hold_left cycles
   int hold_left = 0;
   int gap_cnt = 0;
   int spwe_cnt = 0;
   bit prev_stall = 0;
   logic        prev_wr;
   logic [15:0] prev_addr;
   logic [15:0] prev_wdata;

   assign reg_rdata = regfile[reg_idx];

   function automatic logic [15:0] fill(input logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a stack of words; pushes go low slot first with SP
   // pre-decremented, pops high slot first reading at SP then incrementing.
   task automatic model_issue(input logic [15:0] pm, input logic [15:0] qm, input logic [15:0] sp);
      logic [15:0] s;
      logic [15:0] d;
      int n;
      bus_t b;
      wb_t w;
      done_t r;
      s = sp;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (pm[i]) begin
            s = s - 16'd2;
            d = (i == 4) ? sp : regfile[i];
            b.wr = 1'b1; b.addr = s; b.data = d;
            bus_q.push_back(b);
            ref_mem[s] = d;
            n++;
         end
      end
      for (int i = 15; i >= 0; i--) begin
         if (qm[i]) begin
            d = ref_mem.exists(s) ? ref_mem[s] : fill(s);
            b.wr = 1'b0; b.addr = s; b.data = d;
            bus_q.push_back(b);
            if (i != 4 && i != 5) begin
               w.idx = 4'(i); w.data = d;
               wb_exp_q.push_back(w);
            end
            s = s + 16'd2;
            n++;
         end
      end
      r.sp = s;
      r.n_spwe = n;
      r.has_items = (n > 0);
`ifdef STACK_SEQ_BACK2BACK_EN
      r.n_gap = 0;
`else
      r.n_gap = (n > 0) ? n - 1 : 0;
`endif
      done_exp_q.push_back(r);
   endtask

   // Bus interface model: answers requests with a configurable stall pattern.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         mem_rdata = '0;
         if (mem_req && !reset) begin
            case (ack_mode)
               0: mem_ack = 1'b1;
               1: mem_ack = ($urandom_range(0, 2) != 0);
               default: begin
                  if (hold_left > 0) hold_left--;
                  else mem_ack = 1'b1;
               end
            endcase
            if (mem_ack && !mem_wr)
               mem_rdata = biu_mem.exists(mem_addr) ? biu_mem[mem_addr] : fill(mem_addr);
            if (mem_ack && mem_wr)
               biu_mem[mem_addr] = mem_wdata;
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   initial begin
      bus_t b;
      wb_t w;
      done_t r;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 0;
         end else begin
            if (sp_we) spwe_cnt++;
            if (busy && !mem_req) gap_cnt++;
            if (prev_stall)
               check("stall_hold", {mem_req, mem_wr, mem_addr, mem_wdata},
                     {1'b1, prev_wr, prev_addr, prev_wdata});
            prev_stall = mem_req && !mem_ack;
            prev_wr = mem_wr;
            prev_addr = mem_addr;
            prev_wdata = mem_wdata;
            if (mem_req && mem_ack) begin
               if (bus_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL bus_unexpected: got wr=%0d addr=0x%0h expected no transfer", mem_wr, mem_addr);
               end else begin
                  b = bus_q.pop_front();
                  check("bus_wr", mem_wr, b.wr);
                  check("bus_addr", mem_addr, b.addr);
                  if (b.wr) check("bus_wdata", mem_wdata, b.data);
                  $display("bus %s addr=0x%04h data=0x%04h", b.wr ? "wr" : "rd", mem_addr,
                           b.wr ? mem_wdata : mem_rdata);
               end
            end
            if (wb_valid) begin
               if (wb_exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL wb_unexpected: got idx=%0d expected no writeback", wb_idx);
               end else begin
                  w = wb_exp_q.pop_front();
                  check("wb_idx", wb_idx, w.idx);
                  check("wb_data", wb_data, w.data);
               end
            end
            if (done) begin
               if (done_exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL done_unexpected: got done=1 expected 0");
               end else begin
                  r = done_exp_q.pop_front();
                  if (r.has_items) check("final_sp", sp_out, r.sp);
                  check("sp_we_count", spwe_cnt, r.n_spwe);
                  check("bubble_count", gap_cnt, r.n_gap);
                  $display("done sp=0x%04h sp_we=%0d bubbles=%0d", sp_out, spwe_cnt, gap_cnt);
               end
               spwe_cnt = 0;
               gap_cnt = 0;
            end
         end
      end
   end

   task automatic flush();
      bus_q.delete();
      wb_exp_q.delete();
      done_exp_q.delete();
      gap_cnt = 0;
      spwe_cnt = 0;
      prev_stall = 0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(posedge clk); #1;
      while (busy && k < 5000) begin
         @(posedge clk); #1;
         k++;
      end
      if (busy) begin
         checks++; errors++;
         $display("FAIL idle_timeout: got busy=1 expected 0");
      end
   endtask

   task automatic issue(input logic [15:0] pm, input logic [15:0] qm, input logic [15:0] sp);
      wait_idle();
      model_issue(pm, qm, sp);
      push_mask = pm; pop_mask = qm; sp_in = sp; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if ((pm | qm) != 16'h0) begin
         check("latency_req", mem_req, 1'b1);
      end else begin
         check("empty_done", {done, mem_req, sp_we}, 3'b100);
      end
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done_exp_q.size() != 0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      if (done_exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL done_timeout: got %0d pending sequences expected 0", done_exp_q.size());
         flush();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [15:0] pm, qm, sp;
      for (int i = 0; i < 16; i++) regfile[i] = 16'($urandom);

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", |{reg_idx, mem_req, mem_wr, mem_addr, mem_wdata, wb_valid, wb_idx,
                               wb_data, sp_out, sp_we, busy, done}, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      ack_mode = 0;
      issue(16'h00FF, 16'h0000, 16'h0100); wait_done();
      issue(16'h0000, 16'h01DF, 16'h00F0); wait_done();
      issue(16'h4C00, 16'h0000, 16'h0000); wait_done();
      issue(16'h0000, 16'h0000, 16'h1234); wait_done();
      issue(16'h0000, 16'h0001, 16'hFFFE); wait_done();
      issue(16'h0003, 16'h0003, 16'h0800); wait_done();

      // Long stall with an ignored start in the middle.
      ack_mode = 2;
      hold_left = 20;
      issue(16'h00F0, 16'h0030, 16'h2000);
      repeat (5) @(posedge clk);
      #1;
      push_mask = 16'hFFFF; pop_mask = 16'hFFFF; sp_in = 16'h7000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_during_stall", busy, 1'b1);
      wait_done();
      ack_mode = 0;

      // Reset during the third of eight pushes, then the same sequence again.
      issue(16'h00FF, 16'h0000, 16'h0300);
      k = 0;
      while (!(mem_req && mem_wr && mem_addr == 16'h02FA) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("third_push_seen", {mem_req, mem_wr, mem_addr}, {2'b11, 16'h02FA});
      reset = 1'b1;
      #1;
      check("midseq_reset_outputs", |{reg_idx, mem_req, mem_wr, mem_addr, mem_wdata, wb_valid,
                                      wb_idx, wb_data, sp_out, sp_we, busy, done}, 1'b0);
      flush();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      issue(16'h00FF, 16'h0000, 16'h0300); wait_done();

      for (int t = 0; t < 40; t++) begin
         ack_mode = int'($urandom_range(0, 1));
         pm = 16'($urandom & $urandom);
         qm = 16'($urandom & $urandom);
         sp = 16'($urandom) & 16'hFFFE;
         issue(pm, qm, sp);
         wait_done();
      end

      repeat (4) @(negedge clk);
      check("bus_queue_empty", bus_q.size(), 0);
      check("wb_queue_empty", wb_exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
